// File: rtl/mem_port_arbiter_if.sv
// Data-memory port bundle shared by the CPU MEM stage, the DMA master
// and the memory itself; the arbiter takes the slave view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_we
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, a starvation counter
// forces bounded DMA bursts that stall the pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int BURST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] DMA_OWN = 1'b1;
  localparam logic [3:0] MAXW    = 4'(MAX_WAIT);
  localparam logic [3:0] BURSTL  = 4'(BURST);

  logic [0:0]        fsm_q, fsm_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              cpu_acc;
  logic              gnt_raw;
  logic              gnt;

  always_comb begin
    cpu_acc     = bus.cpu_rd | bus.cpu_wr;
    gnt_raw     = 1'b0;
    fsm_d       = fsm_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    unique case (fsm_q)
      NORMAL: begin
        if (bus.dma_req && wait_cnt_q == MAXW) begin
          gnt_raw    = 1'b1;
          wait_cnt_d = 4'd0;
          // the forced grant is itself the first beat of the burst
          if (BURSTL == 4'd1) begin
            fsm_d       = NORMAL;
            burst_cnt_d = 4'd0;
          end else begin
            fsm_d       = DMA_OWN;
            burst_cnt_d = 4'd1;
          end
        end else if (cpu_acc) begin
          if (bus.dma_req && wait_cnt_q < MAXW)
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else if (bus.dma_req) begin
          gnt_raw    = 1'b1;
          wait_cnt_d = 4'd0;
        end
      end
      DMA_OWN: begin
        wait_cnt_d = 4'd0;
        if (bus.dma_req) begin
          gnt_raw = 1'b1;
          if (burst_cnt_q + 4'd1 >= BURSTL) begin
            fsm_d       = NORMAL;
            burst_cnt_d = 4'd0;
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else begin
          fsm_d       = NORMAL;
          burst_cnt_d = 4'd0;
        end
      end
      default: begin
        fsm_d       = NORMAL;
        wait_cnt_d  = 4'd0;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // outputs are quiet while reset is held, independent of the clock
  assign gnt = gnt_raw & ~reset;

  always_comb begin
    mem_addr_d  = gnt ? bus.dma_addr  : bus.cpu_addr;
    mem_wdata_d = gnt ? bus.dma_wdata : bus.cpu_wdata;
  end

  assign bus.dma_gnt   = gnt;
  assign bus.cpu_stall = cpu_acc & gnt;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_we    = ~reset & (gnt ? bus.dma_we  : bus.cpu_wr);
  assign bus.mem_rd    = ~reset & (gnt ? ~bus.dma_we : bus.cpu_rd);
  assign bus.cpu_rdata = bus.mem_rdata;

  always_comb begin
    dma_rvalid_d = gnt & ~bus.dma_we;
    dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata : dma_rdata_q;
  end

  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q        <= NORMAL;
      wait_cnt_q   <= 4'd0;
      burst_cnt_q  <= 4'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      wait_cnt_q   <= wait_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end
endmodule
